alu_share_ctrl: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 12 +
 rtl/rr_arb2.sv | 9 +
 rtl/alu_share_ctrl.sv | 82 ++++++++
 tb/tb_alu_share_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: op codes and FSM state encoding shared by the ALU share controller
package alu_ctrl_pkg;
    localparam logic [2:0] OP_ADD        = 3'd0;
    localparam logic [2:0] OP_SUB        = 3'd1;
    localparam logic [2:0] OP_MUL        = 3'd2;
    localparam logic [2:0] OP_NAND       = 3'd3;
    localparam logic [2:0] OP_NOR        = 3'd4;
    localparam logic [2:0] OP_LAST_LEGAL = 3'd4;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant, favouring the requester not granted last
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    // on contention pick the requester that did not win last time
    always_comb grant = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external ALU between two requesters with tagged responses
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid_in,
    output logic [1:0]              req_ready_out,
    input  logic [2:0]              req_op0_in,
    input  logic [2:0]              req_op1_in,
    input  logic [DATA_WIDTH-1:0]   req_a0_in,
    input  logic [DATA_WIDTH-1:0]   req_b0_in,
    input  logic [DATA_WIDTH-1:0]   req_a1_in,
    input  logic [DATA_WIDTH-1:0]   req_b1_in,
    output logic [DATA_WIDTH-1:0]   alu_a_out,
    output logic [DATA_WIDTH-1:0]   alu_b_out,
    output logic [2:0]              alu_sel_out,
    input  logic [2*DATA_WIDTH-1:0] alu_q_in,
    output logic                    resp_valid_out,
    input  logic                    resp_ready_in,
    output logic [2*DATA_WIDTH-1:0] resp_q_out,
    output logic                    resp_id_out,
    output logic                    resp_err_out
);
    logic [1:0] state;
    logic       last_grant;
    logic [1:0] grant;
    logic       accept;
    logic       sel;

    rr_arb2 u_arb (
        .req        (req_valid_in),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // grants only in IDLE and never while reset is held; sel picks the granted requester
    always_comb begin
        req_ready_out = (state == IDLE && rst_n) ? grant : 2'b00;
        accept        = |(req_valid_in & req_ready_out);
        sel           = req_ready_out[1];
    end

    // IDLE latches the granted request, EXEC samples the ALU, RESP waits for the consumer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            alu_a_out      <= '0;
            alu_b_out      <= '0;
            alu_sel_out    <= '0;
            resp_valid_out <= 1'b0;
            resp_q_out     <= '0;
            resp_id_out    <= 1'b0;
            resp_err_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    alu_sel_out <= sel ? req_op1_in : req_op0_in;
                    alu_a_out   <= sel ? req_a1_in : req_a0_in;
                    alu_b_out   <= sel ? req_b1_in : req_b0_in;
                    resp_id_out <= sel;
                    last_grant  <= sel;
                    state       <= EXEC;
                end
                EXEC: begin
                    resp_q_out     <= alu_q_in;
                    resp_err_out   <= alu_sel_out > OP_LAST_LEGAL;
                    resp_valid_out <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (resp_ready_in) begin
                    resp_valid_out <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: table-driven scoreboard bench for alu_share_ctrl with a reference ALU
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct {
        bit         id;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] q;
        bit         err;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        bit         id;
        bit         err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid_in;
    logic [1:0] req_ready_out;
    logic [2:0] req_op0_in, req_op1_in;
    logic [3:0] req_a0_in, req_b0_in, req_a1_in, req_b1_in;
    logic [3:0] alu_a_out, alu_b_out;
    logic [2:0] alu_sel_out;
    logic [7:0] alu_q_in;
    logic       resp_valid_out;
    logic       resp_ready_in;
    logic [7:0] resp_q_out;
    logic       resp_id_out;
    logic       resp_err_out;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t tbl[8];
    exp_t e;

    alu_share_ctrl #(.DATA_WIDTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_op0_in     (req_op0_in),
        .req_op1_in     (req_op1_in),
        .req_a0_in      (req_a0_in),
        .req_b0_in      (req_b0_in),
        .req_a1_in      (req_a1_in),
        .req_b1_in      (req_b1_in),
        .alu_a_out      (alu_a_out),
        .alu_b_out      (alu_b_out),
        .alu_sel_out    (alu_sel_out),
        .alu_q_in       (alu_q_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .resp_q_out     (resp_q_out),
        .resp_id_out    (resp_id_out),
        .resp_err_out   (resp_err_out)
    );

    // standard ALU sitting outside the controller
    always_comb begin
        alu_q_in = 8'h00;
        case (alu_sel_out)
            3'd0: alu_q_in = {4'h0, alu_a_out} + {4'h0, alu_b_out};
            3'd1: alu_q_in = {4'h0, alu_a_out} - {4'h0, alu_b_out};
            3'd2: alu_q_in = {4'h0, alu_a_out} * {4'h0, alu_b_out};
            3'd3: alu_q_in = {4'h0, ~(alu_a_out & alu_b_out)};
            3'd4: alu_q_in = {4'h0, ~(alu_a_out | alu_b_out)};
            default: alu_q_in = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (r) begin
            req_op1_in = op; req_a1_in = a; req_b1_in = b;
        end else begin
            req_op0_in = op; req_a0_in = a; req_b0_in = b;
        end
    endtask

    task automatic issue(input bit r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] q, input bit err);
        int t = 0;
        @(negedge clk);
        set_req(r, op, a, b);
        req_valid_in[r] = 1'b1;
        #1;
        while (!req_ready_out[r] && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!req_ready_out[r]) begin
            chk("grant_timeout", 0, 1);
            req_valid_in[r] = 1'b0;
        end else begin
            sb.push_back('{q, r, err});
            @(posedge clk);
            #1;
            req_valid_in[r] = 1'b0;
            chk("alu_sel", alu_sel_out, op);
            chk("alu_a", alu_a_out, a);
            chk("alu_b", alu_b_out, b);
            chk("valid_exec", resp_valid_out, 0);
            @(posedge clk);
            #1;
            chk("latency_valid", resp_valid_out, 1);
        end
    endtask

    task automatic collect();
        int t = 0;
        exp_t x;
        resp_ready_in = 1'b1;
        while (!resp_valid_out && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!resp_valid_out) chk("resp_timeout", 0, 1);
        else if (sb.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
            x = sb.pop_front();
            chk("resp_q", resp_q_out, x.q);
            chk("resp_id", resp_id_out, x.id);
            chk("resp_err", resp_err_out, x.err);
            chk("ready_in_resp", req_ready_out, 0);
            @(posedge clk);
            #1;
            chk("resp_done", resp_valid_out, 0);
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, OP_ADD,  4'd9,  4'd8,  8'h11, 1'b0};
        tbl[1] = '{1'b1, OP_SUB,  4'd3,  4'd5,  8'hFE, 1'b0};
        tbl[2] = '{1'b1, OP_MUL,  4'd15, 4'd15, 8'hE1, 1'b0};
        tbl[3] = '{1'b0, 3'd6,    4'd7,  4'd2,  8'h00, 1'b1};
        tbl[4] = '{1'b0, OP_NAND, 4'hC,  4'hA,  8'h07, 1'b0};
        tbl[5] = '{1'b1, OP_NOR,  4'hC,  4'hA,  8'h01, 1'b0};
        tbl[6] = '{1'b0, 3'd7,    4'd3,  4'd3,  8'h00, 1'b1};
        tbl[7] = '{1'b1, OP_ADD,  4'hF,  4'hF,  8'h1E, 1'b0};
        rst_n = 1'b0;
        req_valid_in = 2'b11;
        resp_ready_in = 1'b1;
        set_req(1'b0, OP_ADD, 4'd1, 4'd1);
        set_req(1'b1, OP_ADD, 4'd1, 4'd1);
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready_out, 0);
        chk("rst_valid", resp_valid_out, 0);
        chk("rst_alu", {alu_sel_out, alu_a_out, alu_b_out}, 0);
        chk("rst_resp", {resp_q_out, resp_id_out, resp_err_out}, 0);
        req_valid_in = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].err);
            collect();
        end
        @(negedge clk);
        set_req(1'b0, OP_NAND, 4'hC, 4'hA);
        set_req(1'b1, OP_NOR, 4'hC, 4'hA);
        req_valid_in = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            while (req_ready_out == 2'b00 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("rr_grant", req_ready_out, (k % 2) ? 2'b10 : 2'b01);
            if (k % 2) sb.push_back('{8'h01, 1'b1, 1'b0});
            else sb.push_back('{8'h07, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            collect();
        end
        req_valid_in = 2'b00;
        resp_ready_in = 1'b0;
        issue(1'b0, OP_ADD, 4'd1, 4'd2, 8'h03, 1'b0);
        req_valid_in = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid_out, 1);
            chk("bp_q", resp_q_out, 8'h03);
            chk("bp_id_err", {resp_id_out, resp_err_out}, 2'b00);
            chk("bp_ready", req_ready_out, 2'b00);
        end
        resp_ready_in = 1'b1;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{8'hXX, 1'b1, 1'b1};
        chk("bp_release_q", resp_q_out, e.q);
        @(posedge clk);
        #1;
        chk("bp_done", resp_valid_out, 0);
        chk("bp_next_grant", req_ready_out, 2'b10);
        @(posedge clk);
        #1;
        chk("bp_next_accept", alu_sel_out, OP_NOR);
        req_valid_in = 2'b00;
        sb.push_back('{8'h01, 1'b1, 1'b0});
        collect();
        @(negedge clk);
        set_req(1'b0, OP_ADD, 4'd2, 4'd2);
        req_valid_in = 2'b01;
        #1;
        chk("pre_rst_grant", req_ready_out, 2'b01);
        @(posedge clk);
        #1;
        req_valid_in = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", resp_valid_out, 0);
        chk("mid_rst_alu", {alu_sel_out, alu_a_out, alu_b_out}, 0);
        chk("mid_rst_resp", {resp_q_out, resp_id_out, resp_err_out}, 0);
        chk("mid_rst_ready", req_ready_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_resp_after_rst", resp_valid_out, 0);
        end
        set_req(1'b0, OP_NAND, 4'hC, 4'hA);
        req_valid_in = 2'b11;
        #1;
        chk("post_rst_grant", req_ready_out, 2'b01);
        sb.push_back('{8'h07, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        req_valid_in = 2'b00;
        collect();
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
